// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32 load/store
// funct3 codes, the controller state encoding, and the per-request helpers
// for legality, byte-lane masks and store-data replication.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Active-high mask of the byte lanes touched by an access of this size at this offset.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  // Request is legal when funct3 is defined for its direction and the address is naturally aligned.
  function automatic logic req_legal(input logic we, input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = (off[0] == 1'b0);
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate store data across the word so every candidate lane carries the value.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    d = 32'h0000_0000;
    case (funct3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      F3_W:    d = wdata;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a raw memory word.
// Purely combinational so the writeback mux can reuse it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load type.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = off[1] ? word[31:16] : word[15:0];
    data     = 32'h0000_0000;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h00_0000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      F3_W:    data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: accepts one request, checks legality, runs a
// request/acknowledge memory access with an optional wait-state timeout and
// returns a one-cycle response with extended load data.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_oe,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t       state;
  lsu_state_t       nxt;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_off;
  logic [4:0]       cap_rd;
  logic             legal;
  logic             timeout_hit;
  logic [31:0]      load_data;
  logic             unused_addr_hi;

  // Upper address bits lie outside the data memory window.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign legal       = req_legal(req_we, req_funct3, req_addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TMO_LAST);
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);

  lsu_load_align u_align (
    .funct3 (cap_funct3),
    .off    (cap_off),
    .word   (mem_rdata),
    .data   (load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; an ack in the expiring cycle still completes normally.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) nxt = legal ? ACCESS : RESP;
        else           nxt = IDLE;
      end
      ACCESS: begin
        if (mem_ack)          nxt = RESP;
        else if (timeout_hit) nxt = RESP;
        else                  nxt = ACCESS;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request capture, memory strobes, wait counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_funct3 <= 3'b000;
      cap_off    <= 2'b00;
      cap_rd     <= 5'd0;
      mem_req    <= 1'b0;
      mem_oe     <= 1'b0;
      mem_web    <= 4'hF;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_rd    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_off    <= req_addr[1:0];
            cap_rd     <= req_rd;
            cnt        <= '0;
            mem_addr   <= req_addr[ADDR_W+1:2];
            mem_wdata  <= store_data(req_funct3, req_wdata);
            if (legal) begin
              mem_req <= 1'b1;
              mem_oe  <= ~req_we;
              mem_web <= req_we ? ~byte_mask(req_funct3, req_addr[1:0]) : 4'hF;
            end else begin
              // Rejected at accept: no memory access, error response next cycle.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
              resp_rd    <= req_we ? 5'd0 : req_rd;
            end
          end
        end
        ACCESS: begin
          if (nxt == RESP) begin
            mem_req    <= 1'b0;
            mem_oe     <= 1'b0;
            mem_web    <= 4'hF;
            resp_valid <= 1'b1;
            resp_err   <= ~mem_ack;
            resp_rdata <= (mem_ack && !cap_we) ? load_data : 32'h0000_0000;
            resp_rd    <= cap_we ? 5'd0 : cap_rd;
          end else begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          resp_rd    <= 5'd0;
        end
        default: begin
          mem_req    <= 1'b0;
          mem_oe     <= 1'b0;
          mem_web    <= 4'hF;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          resp_rd    <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_oe;
  logic [3:0]  mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int lat;

  lsu_mem_ctrl #(.ADDR_W(14), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_oe     (mem_oe),
    .mem_web    (mem_web),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accept cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    tick();
    req_valid  = 1'b0;
  endtask

  // Called in the first ACCESS cycle: ack after 'waits' low cycles, bounded wait for resp_valid.
  task automatic finish_access(input int waits, input logic [31:0] rdata, output int l);
    l = 1;
    for (int i = 0; i < 40; i++) begin
      mem_ack   = (i == waits);
      mem_rdata = rdata;
      tick();
      l++;
      if (resp_valid) break;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_rv",    32'(resp_valid), 32'd0);
    chk("rst_err",   32'(resp_err),  32'd0);
    chk("rst_rdata", resp_rdata,     32'h0);
    chk("rst_rd",    32'(resp_rd),   32'd0);
    chk("rst_mreq",  32'(mem_req),   32'd0);
    chk("rst_oe",    32'(mem_oe),    32'd0);
    chk("rst_web",   32'(mem_web),   32'hF);
    rst = 1'b0;
    tick();

    // SW 0x10 with immediate ack
    issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4);
    chk("sw_busy",  32'(busy),     32'd1);
    chk("sw_ready", 32'(req_ready), 32'd0);
    chk("sw_mreq",  32'(mem_req),  32'd1);
    chk("sw_oe",    32'(mem_oe),   32'd0);
    chk("sw_addr",  32'(mem_addr), 32'd4);
    chk("sw_web",   32'(mem_web),  32'h0);
    chk("sw_wdata", mem_wdata,     32'hDEAD_BEEF);
    finish_access(0, 32'h5555_5555, lat);
    chk("sw_lat",   32'(lat),        32'd2);
    chk("sw_err",   32'(resp_err),   32'd0);
    chk("sw_rdata", resp_rdata,      32'h0);
    chk("sw_rd",    32'(resp_rd),    32'd0);
    chk("sw_web_after", 32'(mem_web), 32'hF);
    tick();
    chk("sw_pulse", 32'(resp_valid), 32'd0);
    chk("sw_idle",  32'(req_ready),  32'd1);

    // mem_ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack", 32'(resp_valid), 32'd0);

    // LB 0x13, three wait states
    issue(1'b0, 3'b000, 32'h0000_0013, 32'h0, 5'd5);
    chk("lb_oe",  32'(mem_oe),  32'd1);
    chk("lb_web", 32'(mem_web), 32'hF);
    finish_access(3, 32'h80FF_7F01, lat);
    chk("lb_lat",   32'(lat),     32'd5);
    chk("lb_rdata", resp_rdata,   32'hFFFF_FF80);
    chk("lb_rd",    32'(resp_rd), 32'd5);
    tick();

    // LBU 0x13, three wait states
    issue(1'b0, 3'b100, 32'h0000_0013, 32'h0, 5'd6);
    finish_access(3, 32'h80FF_7F01, lat);
    chk("lbu_lat",   32'(lat),   32'd5);
    chk("lbu_rdata", resp_rdata, 32'h0000_0080);
    tick();

    // SH 0x06
    issue(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 5'd0);
    chk("sh_web",   32'(mem_web),  32'h3);
    chk("sh_wdata", mem_wdata,     32'hABCD_ABCD);
    chk("sh_addr",  32'(mem_addr), 32'd1);
    finish_access(0, 32'h0, lat);
    chk("sh_lat", 32'(lat), 32'd2);
    tick();

    // SB 0x02
    issue(1'b1, 3'b000, 32'h0000_0002, 32'h0000_00A5, 5'd0);
    chk("sb_web",   32'(mem_web), 32'hB);
    chk("sb_wdata", mem_wdata,    32'hA5A5_A5A5);
    finish_access(1, 32'h0, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    tick();

    // LH misaligned 0x03
    issue(1'b0, 3'b001, 32'h0000_0003, 32'h0, 5'd7);
    chk("lhmis_rv",    32'(resp_valid), 32'd1);
    chk("lhmis_err",   32'(resp_err),   32'd1);
    chk("lhmis_mreq",  32'(mem_req),    32'd0);
    chk("lhmis_rdata", resp_rdata,      32'h0);
    tick();
    chk("lhmis_mreq2", 32'(mem_req),    32'd0);
    chk("lhmis_pulse", 32'(resp_valid), 32'd0);

    // Store with load-only funct3 is illegal
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0, 5'd0);
    chk("sbu_err",  32'(resp_err), 32'd1);
    chk("sbu_mreq", 32'(mem_req),  32'd0);
    tick();

    // LHU / LH upper half
    issue(1'b0, 3'b101, 32'h0000_0012, 32'h0, 5'd8);
    finish_access(0, 32'h8001_0000, lat);
    chk("lhu_rdata", resp_rdata, 32'h0000_8001);
    tick();
    issue(1'b0, 3'b001, 32'h0000_0012, 32'h0, 5'd8);
    finish_access(2, 32'h8001_0000, lat);
    chk("lh_lat",   32'(lat),   32'd4);
    chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
    tick();

    // Timeout: no ack for 16 ACCESS cycles
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd10);
    finish_access(100, 32'h1234_5678, lat);
    chk("tmo_lat",   32'(lat),     32'd17);
    chk("tmo_err",   32'(resp_err), 32'd1);
    chk("tmo_rdata", resp_rdata,    32'h0);
    chk("tmo_mreq",  32'(mem_req),  32'd0);
    tick();

    // Ack on the 16th ACCESS cycle wins
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd11);
    finish_access(15, 32'h1234_5678, lat);
    chk("ack16_lat",   32'(lat),      32'd17);
    chk("ack16_err",   32'(resp_err), 32'd0);
    chk("ack16_rdata", resp_rdata,    32'h1234_5678);
    tick();

    // Reset during ACCESS
    issue(1'b0, 3'b010, 32'h0000_0008, 32'h0, 5'd3);
    chk("mid_mreq", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mreq",  32'(mem_req),   32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_oe",    32'(mem_oe),    32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("arst_norv", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("arst_norv2", 32'(resp_valid), 32'd0);
    issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd9);
    chk("lw20_addr", 32'(mem_addr), 32'd8);
    finish_access(1, 32'hCAFE_F00D, lat);
    chk("lw20_lat",   32'(lat),     32'd3);
    chk("lw20_rdata", resp_rdata,   32'hCAFE_F00D);
    chk("lw20_rd",    32'(resp_rd), 32'd9);
    tick();

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0000; req_rd = 5'd1;
    tick();
    chk("b2b_acc_ready", 32'(req_ready), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    chk("b2b_rv1",       32'(resp_valid), 32'd1);
    chk("b2b_rsp_ready", 32'(req_ready),  32'd0);
    chk("b2b_rdata1",    resp_rdata,      32'h1111_2222);
    req_addr = 32'h0000_0004; req_rd = 5'd2;
    tick();
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_mreq",  32'(mem_req),   32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_acc2_mreq", 32'(mem_req),  32'd1);
    chk("b2b_acc2_addr", 32'(mem_addr), 32'd1);
    finish_access(0, 32'h3333_4444, lat);
    chk("b2b_lat2",   32'(lat),     32'd2);
    chk("b2b_rdata2", resp_rdata,   32'h3333_4444);
    chk("b2b_rd2",    32'(resp_rd), 32'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
